fetch_unit: RTL and testbench

Instruction-fetch initiator for the single-port memory block's fetch port: drives `fe_req`/`fe_addr`, consumes `fe_ack`/`fe_data`, and buffers returned instructions in a small queue feeding decode over a valid/ready handshake. It tracks the sequential PC, retries fetches denied because a data-side access has priority, and discards queued and in-flight fetches on a redirect from a later stage.

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: memory fetch port, redirect input and decode handshake.
// The master modport is the fetch unit; the slave side is memory/decode.
interface fetch_unit_if;
  logic        fe_req;
  logic [31:0] fe_addr;
  logic        fe_ack;
  logic [31:0] fe_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        de_valid;
  logic        de_ready;
  logic [31:0] de_inst;
  logic [31:0] de_pc;

  modport master (
    output fe_req, fe_addr,
    input  fe_ack, fe_data,
    input  redirect_valid, redirect_pc,
    output de_valid, de_inst, de_pc,
    input  de_ready
  );

  modport slave (
    input  fe_req, fe_addr,
    output fe_ack, fe_data,
    output redirect_valid, redirect_pc,
    input  de_valid, de_inst, de_pc,
    output de_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch initiator: sequential PC, deny/retry, redirect flush,
// and a small circular instruction queue feeding decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic          started_q;
  logic          infl_q, infl_d;
  logic [31:0]   infl_pc_q, infl_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ent_inst_q [DEPTH];
  logic [31:0]   ent_pc_q   [DEPTH];

  logic          redir;
  logic          de_valid;
  logic          pop;
  logic          push;
  logic          fe_req;
  logic          grant;
  logic [CW:0]   occ;
  logic          unused_rpc;

  assign unused_rpc = &{1'b0, bus.redirect_pc[1:0]};

  assign redir    = bus.redirect_valid;
  assign de_valid = (count_q != '0) & ~redir;
  assign pop      = de_valid & bus.de_ready;
  assign push     = infl_q & ~redir;

  // Credit counts in-flight fetches; a same-cycle pop frees a slot.
  assign occ = {1'b0, count_q}
             + {{CW{1'b0}}, infl_q}
             - {{CW{1'b0}}, pop};

  assign fe_req = started_q & ~redir & (occ < (CW+1)'(DEPTH));
  assign grant  = fe_req & bus.fe_ack;

  assign bus.fe_req   = fe_req;
  assign bus.fe_addr  = pc_q;
  assign bus.de_valid = de_valid;
  assign bus.de_inst  = ent_inst_q[head_q];
  assign bus.de_pc    = ent_pc_q[head_q];

  always_comb begin
    pc_d      = pc_q;
    infl_d    = grant;
    infl_pc_d = infl_pc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    unique case (1'b1)
      redir: begin
        pc_d    = {bus.redirect_pc[31:2], 2'b00};
        infl_d  = 1'b0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
      default: begin
        if (grant) begin
          pc_d      = pc_q + 32'd4;
          infl_pc_d = pc_q;
        end
        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
        count_d = count_q
                + {{(CW-1){1'b0}}, push}
                - {{(CW-1){1'b0}}, pop};
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      started_q <= 1'b0;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      started_q <= 1'b1;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_inst_q[i] <= '0;
        ent_pc_q[i]   <= '0;
      end
    end else if (push) begin
      ent_inst_q[tail_q] <= bus.fe_data;
      ent_pc_q[tail_q]   <= infl_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected instructions are queued by the
// stimulus and checked by an independent decode-side monitor.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset_n;
  logic ack_en;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] exp_q [$];
  logic [31:0] e;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign bus.fe_ack = ack_en & bus.fe_req;

  // Memory returns word = address; garbage after a denied cycle.
  always @(posedge clk)
    bus.fe_data <= (bus.fe_req && bus.fe_ack) ? bus.fe_addr
                                              : 32'hDEAD_BEEF;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    ack_en = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.de_ready = 1'b1;
    exp_q.delete();
    mid();
    chk("rst_fe_req", 32'(bus.fe_req), 32'd0);
    chk("rst_fe_addr", bus.fe_addr, 32'h0);
    chk("rst_de_valid", 32'(bus.de_valid), 32'd0);
    chk("rst_de_inst", bus.de_inst, 32'h0);
    chk("rst_de_pc", bus.de_pc, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    ack_en = 1'b0;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) nxt();
    nxt();
    nxt();
    mid();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_de_valid", 32'(bus.de_valid), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.de_valid && bus.de_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got pc=%h inst=%h want none",
                 bus.de_pc, bus.de_inst);
      end else begin
        e = exp_q.pop_front();
        if (bus.de_pc !== e || bus.de_inst !== e) begin
          n_fail++;
          $display("FAIL pop: got pc=%h inst=%h want %h",
                   bus.de_pc, bus.de_inst, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    ack_en = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.de_ready = 1'b1;

    // Streaming from reset
    do_reset();
    reset_n = 1'b1;
    ack_en = 1'b1;
    expect_seq(32'h0, 6);
    mid();
    chk("c0_no_req", 32'(bus.fe_req), 32'd0);
    for (int c = 1; c <= 6; c++) begin
      nxt();
      mid();
      chk("stream_req", 32'(bus.fe_req), 32'd1);
      chk("stream_addr", bus.fe_addr, 32'(4 * (c - 1)));
      if (c == 2) chk("c2_no_valid", 32'(bus.de_valid), 32'd0);
      if (c == 3) begin
        chk("c3_valid", 32'(bus.de_valid), 32'd1);
        chk("c3_pc", bus.de_pc, 32'h0);
      end
    end
    nxt();
    drain();

    // Denied fetches in cycles 2-4
    do_reset();
    reset_n = 1'b1;
    ack_en = 1'b1;
    expect_seq(32'h0, 3);
    nxt();
    mid();
    chk("deny_c1_addr", bus.fe_addr, 32'h0);
    for (int c = 2; c <= 4; c++) begin
      nxt();
      ack_en = 1'b0;
      mid();
      chk("deny_hold_addr", bus.fe_addr, 32'h4);
      chk("deny_req", 32'(bus.fe_req), 32'd1);
    end
    nxt();
    ack_en = 1'b1;
    mid();
    chk("deny_c5_addr", bus.fe_addr, 32'h4);
    nxt();
    mid();
    chk("deny_c6_addr", bus.fe_addr, 32'h8);
    nxt();
    drain();

    // Decode stall, queue fills, then resumes without gaps
    do_reset();
    bus.de_ready = 1'b0;
    reset_n = 1'b1;
    ack_en = 1'b1;
    expect_seq(32'h0, 6);
    for (int c = 1; c <= 10; c++) begin
      nxt();
      mid();
      if (c >= 3) begin
        chk("stall_no_req", 32'(bus.fe_req), 32'd0);
        chk("stall_head", bus.de_pc, 32'h0);
      end
    end
    nxt();
    bus.de_ready = 1'b1;
    mid();
    chk("resume_req", 32'(bus.fe_req), 32'd1);
    chk("resume_addr", bus.fe_addr, 32'h8);
    for (int c = 12; c <= 16; c++) begin
      nxt();
      if (c == 15) ack_en = 1'b0;
      mid();
      chk("resume_no_gap", 32'(bus.de_valid), 32'd1);
    end
    drain();

    // Redirect with the credit window full and a fetch in flight
    do_reset();
    bus.de_ready = 1'b0;
    reset_n = 1'b1;
    ack_en = 1'b1;
    nxt();
    nxt();
    nxt();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_1003;
    bus.de_ready = 1'b1;
    mid();
    chk("redir_de_valid", 32'(bus.de_valid), 32'd0);
    chk("redir_no_req", 32'(bus.fe_req), 32'd0);
    expect_seq(32'h0000_1000, 3);
    nxt();
    bus.redirect_valid = 1'b0;
    mid();
    chk("redir_r1_addr", bus.fe_addr, 32'h0000_1000);
    chk("redir_r1_req", 32'(bus.fe_req), 32'd1);
    chk("redir_r1_empty", 32'(bus.de_valid), 32'd0);
    nxt();
    mid();
    chk("redir_r2_empty", 32'(bus.de_valid), 32'd0);
    nxt();
    mid();
    chk("redir_r3_valid", 32'(bus.de_valid), 32'd1);
    chk("redir_r3_pc", bus.de_pc, 32'h0000_1000);
    nxt();
    drain();

    // PC wrap at the top of the address space
    nxt();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    nxt();
    bus.redirect_valid = 1'b0;
    ack_en = 1'b1;
    expect_seq(32'hFFFF_FFFC, 2);
    mid();
    chk("wrap_top_addr", bus.fe_addr, 32'hFFFF_FFFC);
    nxt();
    mid();
    chk("wrap_zero_addr", bus.fe_addr, 32'h0);
    nxt();
    drain();

    // Asynchronous reset with two entries queued
    do_reset();
    bus.de_ready = 1'b0;
    reset_n = 1'b1;
    ack_en = 1'b1;
    nxt();
    nxt();
    nxt();
    nxt();
    bus.de_ready = 1'b1;
    #1;
    chk("pre_rst_valid", 32'(bus.de_valid), 32'd1);
    chk("pre_rst_req", 32'(bus.fe_req), 32'd1);
    chk("pre_rst_addr", bus.fe_addr, 32'h8);
    reset_n = 1'b0;
    #1;
    chk("arst_de_valid", 32'(bus.de_valid), 32'd0);
    chk("arst_fe_req", 32'(bus.fe_req), 32'd0);
    chk("arst_fe_addr", bus.fe_addr, 32'h0);
    chk("arst_de_pc", bus.de_pc, 32'h0);
    nxt();
    nxt();
    reset_n = 1'b1;
    expect_seq(32'h0, 2);
    nxt();
    mid();
    chk("rest_c1_addr", bus.fe_addr, 32'h0);
    nxt();
    mid();
    chk("rest_c2_addr", bus.fe_addr, 32'h4);
    nxt();
    ack_en = 1'b0;
    mid();
    chk("rest_c3_valid", 32'(bus.de_valid), 32'd1);
    chk("rest_c3_pc", bus.de_pc, 32'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
